// File: rtl/token_ring_bus_bridge.sv
// Token-ring bus bridge: joins reset-time enumeration, waits for its token,
// then grants internal requesters round-robin onto the shared external bus
// for a bounded burst, aborting transfers that never complete.
module token_ring_bus_bridge #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 32,
    parameter int NPORT     = 3,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                      clk,
    input  logic                      ext_rst_b,
    input  logic                      enum_valid,
    input  logic [IDX_W-1:0]          enum_index,
    output logic                      enum_done,
    output logic [IDX_W-1:0]          my_index,
    input  logic [NPORT-1:0]          req_valid,
    input  logic [NPORT-1:0]          req_we,
    input  logic [NPORT*ADDR_W-1:0]   req_addr,
    input  logic [NPORT*DATA_W-1:0]   req_wdata,
    output logic [NPORT-1:0]          req_ready,
    output logic [NPORT-1:0]          rsp_valid,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_rdata,
    input  logic                      tok_in,
    input  logic [IDX_W-1:0]          tok_in_index,
    output logic                      tok_pass,
    output logic                      online,
    output logic                      ext_read_q,
    output logic                      ext_write_q,
    output logic [ADDR_W-1:0]         ext_addr,
    output logic [DATA_W-1:0]         ext_wdata,
    input  logic [DATA_W-1:0]         ext_rdata,
    input  logic                      ext_done
);

    localparam int PTR_W   = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int TMO_W   = $clog2(TIMEOUT);
    localparam logic [NPORT-1:0] PORT_ONE = 1;

    // RESP is the cycle after a good completion; it carries the response
    // pulse and decides between another grant and giving up the token.
    // An empty token hit goes straight to RELEASE, which produces the pass pulse.
    typedef enum logic [2:0] {ENUM, IDLE, GRANT, XFER, RESP, RELEASE} state_t;

    state_t              state_reg, state_next;
    logic [PTR_W-1:0]    ptr_reg;
    logic [PTR_W-1:0]    cur_port_reg;
    logic [BURST_W-1:0]  burst_reg;
    logic [TMO_W-1:0]    tmo_reg;
    logic [IDX_W-1:0]    my_index_reg;
    logic                enum_done_reg;
    logic [NPORT-1:0]    rsp_valid_reg;
    logic                rsp_err_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    logic                ext_read_q_reg, ext_write_q_reg;
    logic [ADDR_W-1:0]   ext_addr_reg;
    logic [DATA_W-1:0]   ext_wdata_reg;

    logic [ADDR_W-1:0]   port_addr  [NPORT];
    logic [DATA_W-1:0]   port_wdata [NPORT];
    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic                tok_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_unpack
            assign port_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign port_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign tok_hit = tok_in && (tok_in_index == my_index_reg);

    // Round-robin pick: first requesting port at or above the pointer, wrapping.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NPORT; i++) begin
            cand = int'(ptr_reg) + i;
            if (cand >= NPORT) cand = cand - NPORT;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ENUM:    if (enum_valid) state_next = IDLE;
            IDLE:    if (tok_hit) state_next = (|req_valid) ? GRANT : RELEASE;
            GRANT:   state_next = grant_found ? XFER : RELEASE;
            XFER: begin
                if (ext_done)                           state_next = RESP;
                else if (tmo_reg == TMO_W'(TIMEOUT-1))  state_next = RELEASE;
            end
            RESP:    state_next = ((burst_reg == BURST_W'(MAX_BURST)) || !(|req_valid))
                                  ? RELEASE : GRANT;
            RELEASE: state_next = IDLE;
            default: state_next = ENUM;
        endcase
    end

    // State, transfer registers and one-cycle response/enumeration pulses.
    always_ff @(posedge clk) begin
        if (!ext_rst_b) begin
            state_reg       <= ENUM;
            ptr_reg         <= '0;
            cur_port_reg    <= '0;
            burst_reg       <= '0;
            tmo_reg         <= '0;
            my_index_reg    <= '1;
            enum_done_reg   <= 1'b0;
            rsp_valid_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_rdata_reg   <= '0;
            ext_read_q_reg  <= 1'b0;
            ext_write_q_reg <= 1'b0;
            ext_addr_reg    <= '0;
            ext_wdata_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            enum_done_reg <= 1'b0;
            rsp_valid_reg <= '0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            case (state_reg)
                ENUM: begin
                    if (enum_valid) begin
                        my_index_reg  <= enum_index;
                        enum_done_reg <= 1'b1;
                    end
                end
                IDLE: begin
                    if (tok_hit && (|req_valid)) burst_reg <= '0;
                end
                GRANT: begin
                    if (grant_found) begin
                        cur_port_reg    <= grant_idx;
                        ext_addr_reg    <= port_addr[grant_idx];
                        ext_wdata_reg   <= port_wdata[grant_idx];
                        ext_write_q_reg <= req_we[grant_idx];
                        ext_read_q_reg  <= !req_we[grant_idx];
                        ptr_reg         <= (grant_idx == PTR_W'(NPORT-1)) ? '0 : grant_idx + 1'b1;
                        tmo_reg         <= '0;
                    end
                end
                XFER: begin
                    tmo_reg <= tmo_reg + 1'b1;
                    if (ext_done) begin
                        ext_read_q_reg  <= 1'b0;
                        ext_write_q_reg <= 1'b0;
                        rsp_valid_reg   <= PORT_ONE << cur_port_reg;
                        rsp_rdata_reg   <= ext_write_q_reg ? '0 : ext_rdata;
                        burst_reg       <= burst_reg + 1'b1;
                    end else if (tmo_reg == TMO_W'(TIMEOUT-1)) begin
                        ext_read_q_reg  <= 1'b0;
                        ext_write_q_reg <= 1'b0;
                        rsp_valid_reg   <= PORT_ONE << cur_port_reg;
                        rsp_err_reg     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (state_reg == GRANT && grant_found) ? (PORT_ONE << grant_idx) : '0;
    assign online      = (state_reg == GRANT) || (state_reg == XFER) || (state_reg == RESP);
    assign tok_pass    = (state_reg == RELEASE);
    assign enum_done   = enum_done_reg;
    assign my_index    = my_index_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign ext_read_q  = ext_read_q_reg;
    assign ext_write_q = ext_write_q_reg;
    assign ext_addr    = ext_addr_reg;
    assign ext_wdata   = ext_wdata_reg;

endmodule
